// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one register-file write port between NREQ writeback sources.
// Optional macro REGWR_TRACE_EN elaborates a negedge write trace with a cycle counter.
module regfile_wr_arbiter #(
    parameter  int NREQ = 2,
    parameter  int n    = 5,
    parameter  int m    = 32,
    parameter  int CW   = 16,
    localparam int LGW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*n-1:0] req_addr,
    input  logic [NREQ*m-1:0] req_data,
    input  logic              stall,
    output logic              rf_we,
    output logic [n-1:0]      rf_a3,
    output logic [m-1:0]      rf_wd,
    output logic [LGW-1:0]    last_grant,
    output logic [CW-1:0]     conflict_cnt
);

    typedef enum logic {IDLE, WRITE} state_t;

    localparam logic [LGW-1:0] LAST_IDX = LGW'(NREQ - 1);

    state_t          state_q, state_d;
    logic [n-1:0]    a3_q, a3_d;
    logic [m-1:0]    wd_q, wd_d;
    logic [LGW-1:0]  last_grant_q, last_grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [n-1:0]    addr_arr [NREQ];
    logic [m-1:0]    data_arr [NREQ];

    logic            grant_found;
    logic [LGW-1:0]  grant_idx;
    logic [LGW-1:0]  scan_idx;
    logic            transfer;
    logic            wr_accept;
    logic            contended;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*n +: n];
            assign data_arr[gi] = req_data[gi*m +: m];
        end
    endgenerate

    // Rotating priority scan; the wrap compares against NREQ-1 so any NREQ works.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = (last_grant_q == LAST_IDX) ? '0 : last_grant_q + 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
            scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
        end
    end

    assign transfer  = grant_found & ~stall;
    assign wr_accept = transfer && (addr_arr[grant_idx] != '0);
    // Two or more set bits: clearing the lowest one leaves something behind.
    assign contended = |(req_valid & (req_valid - 1'b1));

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = wr_accept ? WRITE : IDLE;
            WRITE:   state_d = wr_accept ? WRITE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rf_we = (state_q == WRITE);
    end

    always_comb begin
        a3_d         = a3_q;
        wd_d         = wd_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        if (wr_accept) begin
            a3_d = addr_arr[grant_idx];
            wd_d = data_arr[grant_idx];
        end
        if (transfer) begin
            last_grant_d = grant_idx;
        end
        if (contended && !stall && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a3_q         <= '0;
            wd_q         <= '0;
            last_grant_q <= LAST_IDX;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            a3_q         <= a3_d;
            wd_q         <= wd_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign rf_a3        = a3_q;
    assign rf_wd        = wd_q;
    assign last_grant   = last_grant_q;
    assign conflict_cnt = cnt_q;

`ifdef REGWR_TRACE_EN
    logic [31:0] trace_cycle_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_cycle_q <= '0;
        end else begin
            trace_cycle_q <= trace_cycle_q + 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            $display("[%0d] rf write a3=%0d wd=%032b", trace_cycle_q, rf_a3, rf_wd);
        end
        if (rst_n && transfer && (addr_arr[grant_idx] == '0)) begin
            $display("[%0d] write to r0 from requester %0d discarded", trace_cycle_q, grant_idx);
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter (NREQ=2): per-cycle reference model plus literal checks.
module tb_regfile_wr_arbiter;

    localparam int NREQ = 2;
    localparam int NA   = 5;
    localparam int MD   = 32;

    logic            clk;
    logic            rst_n;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready, req_ready2;
    logic [NREQ*NA-1:0] req_addr;
    logic [NREQ*MD-1:0] req_data;
    logic            stall;
    logic            rf_we, rf_we2;
    logic [NA-1:0]   rf_a3, rf_a32;
    logic [MD-1:0]   rf_wd, rf_wd2;
    logic            last_grant, last_grant2;
    logic [15:0]     conflict_cnt;
    logic [1:0]      conflict_cnt2;

    int checks   = 0;
    int failures = 0;

    regfile_wr_arbiter #(.NREQ(NREQ), .n(NA), .m(MD), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .stall(stall), .rf_we(rf_we),
        .rf_a3(rf_a3), .rf_wd(rf_wd), .last_grant(last_grant), .conflict_cnt(conflict_cnt)
    );

    regfile_wr_arbiter #(.NREQ(NREQ), .n(NA), .m(MD), .CW(2)) dut_cw2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
        .req_addr(req_addr), .req_data(req_data), .stall(stall), .rf_we(rf_we2),
        .rf_a3(rf_a32), .rf_wd(rf_wd2), .last_grant(last_grant2), .conflict_cnt(conflict_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the rules applied with plain integer arithmetic.
    bit          m_we;
    int unsigned m_a3, m_wd;
    int          m_last, m_cnt, m_cnt2;

    always @(negedge clk) begin
        int g;
        int idx;
        int unsigned a;
        logic [NREQ-1:0] exp_ready;
        if (!rst_n) begin
            m_we = 0; m_a3 = 0; m_wd = 0; m_last = NREQ - 1; m_cnt = 0; m_cnt2 = 0;
        end
        g = -1;
        if (!stall) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (m_last + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("model_ready", 64'(req_ready), 64'(exp_ready));
        chk("model_ready_cw2", 64'(req_ready2), 64'(exp_ready));
        chk("model_we", 64'(rf_we), 64'(m_we));
        chk("model_a3", 64'(rf_a3), 64'(m_a3));
        chk("model_wd", 64'(rf_wd), 64'(m_wd));
        chk("model_last_grant", 64'(last_grant), 64'(m_last));
        chk("model_cnt", 64'(conflict_cnt), 64'(m_cnt));
        chk("model_cnt_cw2", 64'(conflict_cnt2), 64'(m_cnt2));
        if (rst_n) begin
            m_we = 0;
            if (g >= 0) begin
                m_last = g;
                a = 32'(req_addr[g*NA +: NA]);
                if (a != 0) begin
                    m_we = 1;
                    m_a3 = a;
                    m_wd = req_data[g*MD +: MD];
                end
            end
            if ($countones(req_valid) >= 2 && !stall) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
    end

    task automatic set_req(input logic [1:0] v, input logic [NA-1:0] a0, input logic [MD-1:0] d0,
                           input logic [NA-1:0] a1, input logic [MD-1:0] d1);
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_cw2 [6];
        exp_cw2 = '{1, 2, 3, 3, 3, 3};
        rst_n = 1'b0;
        stall = 1'b0;
        set_req(2'b00, 0, 0, 0, 0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_a3", 64'(rf_a3), 64'd0);
        chk("rst_wd", 64'(rf_wd), 64'd0);
        chk("rst_cnt", 64'(conflict_cnt), 64'd0);
        chk("rst_last_grant", 64'(last_grant), 64'd1);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single write from requester 0
        @(posedge clk); #1 set_req(2'b01, 5'd3, 32'hDEADBEEF, 0, 0);
        @(negedge clk); #1 chk("t1_ready", 64'(req_ready), 64'b01);
        @(posedge clk); #1 set_req(2'b00, 0, 0, 0, 0);
        @(negedge clk); #1;
        chk("t1_we", 64'(rf_we), 64'd1);
        chk("t1_a3", 64'(rf_a3), 64'd3);
        chk("t1_wd", 64'(rf_wd), 64'hDEADBEEF);
        chk("t1_last_grant", 64'(last_grant), 64'd0);

        // Both requesters continuously valid from fresh priority
        pulse_reset();
        set_req(2'b11, 5'd1, 32'h11, 5'd2, 32'h22);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("t2_ready", 64'(req_ready), (k % 2 == 0) ? 64'b01 : 64'b10);
            if (k > 0) begin
                chk("t2_we", 64'(rf_we), 64'd1);
                chk("t2_a3", 64'(rf_a3), (k % 2 == 1) ? 64'd1 : 64'd2);
            end
            @(posedge clk); #1;
        end
        set_req(2'b00, 0, 0, 0, 0);
        @(negedge clk); #1;
        chk("t2_we_last", 64'(rf_we), 64'd1);
        chk("t2_a3_last", 64'(rf_a3), 64'd2);
        chk("t2_cnt", 64'(conflict_cnt), 64'd4);

        // Write to r5, then a discarded write to r0
        @(posedge clk); #1 set_req(2'b01, 5'd5, 32'h55, 0, 0);
        @(negedge clk); #1 chk("t3_ready0", 64'(req_ready), 64'b01);
        @(posedge clk); #1 set_req(2'b10, 0, 0, 5'd0, 32'hFFFFFFFF);
        @(negedge clk); #1;
        chk("t3_ready1", 64'(req_ready), 64'b10);
        chk("t3_we5", 64'(rf_we), 64'd1);
        chk("t3_a3_5", 64'(rf_a3), 64'd5);
        @(posedge clk); #1 set_req(2'b00, 0, 0, 0, 0);
        @(negedge clk); #1;
        chk("t3_we_r0", 64'(rf_we), 64'd0);
        chk("t3_a3_hold", 64'(rf_a3), 64'd5);
        chk("t3_wd_hold", 64'(rf_wd), 64'h55);
        chk("t3_last_grant", 64'(last_grant), 64'd1);

        // Stall with both valid for three cycles
        @(posedge clk); #1;
        stall = 1'b1;
        set_req(2'b11, 5'd1, 32'h11, 5'd2, 32'h22);
        repeat (3) begin
            @(negedge clk); #1;
            chk("t4_ready_stall", 64'(req_ready), 64'b00);
            chk("t4_we_stall", 64'(rf_we), 64'd0);
            chk("t4_cnt_stall", 64'(conflict_cnt), 64'd4);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        @(negedge clk); #1 chk("t4_first_after", 64'(req_ready), 64'b01);
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("t4_second_after", 64'(req_ready), 64'b10);
        chk("t4_we_after", 64'(rf_we), 64'd1);

        // Asynchronous reset while a write is on the port
        @(posedge clk); #1 chk("t5_we_before", 64'(rf_we), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_we_async", 64'(rf_we), 64'd0);
        chk("t5_a3_async", 64'(rf_a3), 64'd0);
        chk("t5_wd_async", 64'(rf_wd), 64'd0);
        chk("t5_cnt_async", 64'(conflict_cnt), 64'd0);
        chk("t5_last_grant", 64'(last_grant), 64'd1);
        set_req(2'b00, 0, 0, 0, 0);
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;

        // Saturation of a 2-bit conflict counter
        set_req(2'b11, 5'd7, 32'h77, 5'd8, 32'h88);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk); #1;
            chk("t6_cnt_cw2", 64'(conflict_cnt2), 64'(exp_cw2[k]));
        end
        @(posedge clk); #1 set_req(2'b00, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
